// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC serializer slice.
package audio_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int DEFAULT_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample-in / codec-pins bundle between the sample generator, serializer and DAC pads.
interface audio_dac_serializer_if;
  import audio_pkg::*;

  sample_t sample;
  logic    frame_strobe;
  logic    aud_bclk;
  logic    aud_daclrck;
  logic    aud_dacdat;

  modport master (
    output sample,
    input  frame_strobe,
    input  aud_bclk,
    input  aud_daclrck,
    input  aud_dacdat
  );

  modport slave (
    input  sample,
    output frame_strobe,
    output aud_bclk,
    output aud_daclrck,
    output aud_dacdat
  );

endinterface

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clk cycles and flags the falling edge.
module audio_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  always_comb begin
    tc     = (div_q == DIV_LAST);
    div_d  = tc ? '0 : div_q + DIV_W'(1);
    bclk_d = tc ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk      = bclk_q;
  // Combinational so data-side registers update on the same edge bclk falls.
  assign fall_tick = tc & bclk_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// Mono 24-bit sample to three-wire DAC serializer (I2S by default).
// Define AUDIO_DAC_LEFT_JUSTIFIED_EN for left-justified framing.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int SLOT_W  = DEFAULT_SLOT_W
) (
  input  logic            clk,
  input  logic            reset_n,
  audio_dac_serializer_if.slave bus
);

  localparam int               FRAME_BITS = 2 * SLOT_W;
  localparam int               CNT_W      = $clog2(FRAME_BITS);
  localparam int               IDX_W      = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN   = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_SW     = CNT_W'(SAMPLE_W);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("audio_dac_serializer: CLK_DIV must be at least 1");
  end
  if (SLOT_W < SAMPLE_W + 1) begin : g_bad_slot
    $error("audio_dac_serializer: SLOT_W must be at least SAMPLE_W+1");
  end

  logic             bclk;
  logic             fall_tick;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             strobe_q, strobe_d;
  sample_t          shreg_q, shreg_d;

  logic             frame_start;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] pos;
  logic [IDX_W-1:0] idx;
  logic             bit_v;
  sample_t          src;

  audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bclk),
    .fall_tick (fall_tick)
  );

  always_comb begin
    frame_start = fall_tick && (bitcnt_q == CNT_LAST);
    nxt         = (bitcnt_q == CNT_LAST) ? '0 : bitcnt_q + CNT_W'(1);
    pos         = (nxt >= SLOT_LEN) ? nxt - SLOT_LEN : nxt;
    // On the capture edge the register is still being loaded, so read the input.
    src         = frame_start ? bus.sample : shreg_q;
    idx         = '0;
    bit_v       = 1'b0;
`ifdef AUDIO_DAC_LEFT_JUSTIFIED_EN
    if (pos < CNT_SW) begin
      idx   = IDX_W'(CNT_SW - CNT_W'(1) - pos);
      bit_v = src[idx];
    end
`else
    if ((pos != '0) && (pos <= CNT_SW)) begin
      idx   = IDX_W'(CNT_SW - pos);
      bit_v = src[idx];
    end
`endif

    bitcnt_d = bitcnt_q;
    lrck_d   = lrck_q;
    dat_d    = dat_q;
    shreg_d  = shreg_q;
    strobe_d = frame_start;
    if (fall_tick) begin
      bitcnt_d = nxt;
      lrck_d   = (nxt >= SLOT_LEN);
      dat_d    = bit_v;
      if (frame_start) begin
        shreg_d = bus.sample;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_q <= CNT_LAST;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
      strobe_q <= 1'b0;
      shreg_q  <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
      strobe_q <= strobe_d;
      shreg_q  <= shreg_d;
    end
  end

  assign bus.aud_bclk     = bclk;
  assign bus.aud_daclrck  = lrck_q;
  assign bus.aud_dacdat   = dat_q;
  assign bus.frame_strobe = strobe_q;

endmodule
